pixel_req_gen: RTL

PIXEL_REQ_GEN -- requirements
Module: pixel_req_gen

---
 rtl/pixel_req_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pixel_req_gen.sv
// Per-pixel request generator: each pixel latches an event into a pending request,
// releases it on grant, then sits out a refractory period before accepting again.
module pixel_req_gen #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int REF_CYCLES = 8,
  parameter int DROP_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [ROWS-1:0][COLS-1:0]  event_i,
  input  logic [ROWS-1:0][COLS-1:0]  gnt_i,
  output logic [ROWS-1:0][COLS-1:0]  req_o,
  output logic                       active_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       gnt_err_o
);

  localparam int NPIX  = ROWS * COLS;
  localparam int POP_W = $clog2(NPIX + 1);
  localparam int SUM_W = ((DROP_W > POP_W) ? DROP_W : POP_W) + 1;
  localparam logic [7:0]       REF_LD   = 8'(REF_CYCLES);
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  // Handshake: req stays high from the cycle after an accepted event until the
  // first cycle in which gnt is sampled high; a grant never waits on anything else.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    REFRACT = 2'd2
  } pix_state_e;

  logic [NPIX-1:0] drop_vec;
  logic [NPIX-1:0] err_vec;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pix_state_e state_q, state_d;
      logic [7:0] cnt_q, cnt_d;
      logic       req_q;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          req_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          req_q   <= (state_d == PENDING);
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          case (state_q)
            IDLE: if (event_i[r][c]) state_d = PENDING;
            PENDING: begin
              if (gnt_i[r][c]) begin
                if (REF_CYCLES > 0) begin
                  state_d = REFRACT;
                  cnt_d   = REF_LD;
                end else begin
                  state_d = IDLE;
                end
              end
            end
            REFRACT: begin
              if (cnt_q <= 8'd1) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
              end else begin
                cnt_d = cnt_q - 8'd1;
              end
            end
            default: begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end
          endcase
        end
      end

      // Any enabled event outside IDLE is lost, including one coinciding with a grant.
      assign drop_vec[r*COLS+c] = enable_i & event_i[r][c] & (state_q != IDLE);
      assign err_vec[r*COLS+c]  = gnt_i[r][c] & (state_q != PENDING);
      assign req_o[r][c]        = req_q;
    end
  end

  logic [POP_W-1:0] drop_pop;
  logic [SUM_W-1:0] drop_sum;
  logic [DROP_W-1:0] drop_cnt_q;
  logic active_q, err_q;

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NPIX; i++) drop_pop = drop_pop + POP_W'(drop_vec[i]);
  end

  assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : DROP_W'(drop_sum);
      active_q   <= |req_o;
      err_q      <= err_q | (|err_vec);
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign active_o   = active_q;
  assign gnt_err_o  = err_q;

endmodule
